// File: rtl/uart_boot_pkg.sv
// rtl/uart_boot_pkg.sv - shared constants and state encoding for the UART boot-command parser
//
// Contents:
//   HDR_B0/HDR_B1        frame header bytes
//   CMD_REBOOT/CMD_PING  accepted command codes
//   RSP_ACK/RSP_NAK      response bytes returned to uart_tx
//   ST_*_ENC / state_t   parser state encoding

package uart_boot_pkg;

    localparam logic [7:0] HDR_B0     = 8'h55;
    localparam logic [7:0] HDR_B1     = 8'hAA;
    localparam logic [7:0] CMD_REBOOT = 8'h01;
    localparam logic [7:0] CMD_PING   = 8'h02;
    localparam logic [7:0] RSP_ACK    = 8'h06;
    localparam logic [7:0] RSP_NAK    = 8'h15;

    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_HDR2_ENC = 3'd1;
    localparam logic [2:0] ST_CMD_ENC  = 3'd2;
    localparam logic [2:0] ST_ADR2_ENC = 3'd3;
    localparam logic [2:0] ST_ADR1_ENC = 3'd4;
    localparam logic [2:0] ST_ADR0_ENC = 3'd5;
    localparam logic [2:0] ST_CHK_ENC  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE_ENC,
        S_HDR2 = ST_HDR2_ENC,
        S_CMD  = ST_CMD_ENC,
        S_ADR2 = ST_ADR2_ENC,
        S_ADR1 = ST_ADR1_ENC,
        S_ADR0 = ST_ADR0_ENC,
        S_CHK  = ST_CHK_ENC
    } state_t;

endpackage

// File: rtl/uart_byte_timeout.sv
// rtl/uart_byte_timeout.sv - inter-byte timeout counter with clear, enable and terminal count
//
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   clr    in   restart the count from zero (a byte arrived)
//   en     in   count while high; held at zero while low
//   tc     out  high while the count sits at TIMEOUT_CYC-1 and counting is enabled

module uart_byte_timeout #(
    parameter int TIMEOUT_CYC = 500000,
    parameter int CNT_W       = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tc = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || !en || tc) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_boot_cmd_parser.sv
// rtl/uart_boot_cmd_parser.sv - parses 7-byte boot-command frames from uart_rx and issues warm-boot requests
//
// Ports:
//   sclk       in   system clock
//   rst_n      in   synchronous active-low reset
//   po_data    in   received byte, valid with po_flag
//   po_flag    in   one-cycle strobe per received byte
//   icap_busy  in   ICAP controller cannot accept a boot request
//   boot_addr  out  warm-boot start address, updated only on an accepted reboot
//   boot_req   out  one-cycle boot request pulse
//   tx_byte    out  response byte (ACK/NAK), held until the next response
//   tx_req     out  one-cycle strobe to send tx_byte
//   frame_err  out  one-cycle pulse when a partial frame is dropped on timeout

module uart_boot_cmd_parser
    import uart_boot_pkg::*;
#(
    parameter int TIMEOUT_CYC = 500000,
    parameter int CNT_W       = 20
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic [7:0]  po_data,
    input  logic        po_flag,
    input  logic        icap_busy,
    output logic [23:0] boot_addr,
    output logic        boot_req,
    output logic [7:0]  tx_byte,
    output logic        tx_req,
    output logic        frame_err
);

    state_t     state_q, state_d;
    logic [7:0] cmd_q, a2_q, a1_q, a0_q, xor_q;
    logic       tmo_tc;
    logic       eval;
    logic       abort;
    logic       is_reboot;
    logic       frame_ok;

    uart_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk   (sclk),
        .rst_n (rst_n),
        .clr   (po_flag),
        .en    (state_q != S_IDLE),
        .tc    (tmo_tc)
    );

    // Evaluated against the byte currently on po_data, which is CHK when eval fires.
    assign is_reboot = (cmd_q == CMD_REBOOT);
    assign frame_ok  = (po_data == xor_q)
                    && (is_reboot || (cmd_q == CMD_PING))
                    && !(is_reboot && icap_busy);

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A byte arriving on the terminal-count cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        eval    = 1'b0;
        abort   = 1'b0;
        if (po_flag) begin
            unique case (state_q)
                S_IDLE: if (po_data == HDR_B0) state_d = S_HDR2;
                S_HDR2: begin
                    if (po_data == HDR_B1) begin
                        state_d = S_CMD;
                    end else if (po_data != HDR_B0) begin
                        state_d = S_IDLE;
                    end
                end
                S_CMD:  state_d = S_ADR2;
                S_ADR2: state_d = S_ADR1;
                S_ADR1: state_d = S_ADR0;
                S_ADR0: state_d = S_CHK;
                S_CHK: begin
                    state_d = S_IDLE;
                    eval    = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_tc) begin
            state_d = S_IDLE;
            abort   = 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            a2_q      <= '0;
            a1_q      <= '0;
            a0_q      <= '0;
            xor_q     <= '0;
            boot_addr <= '0;
            boot_req  <= 1'b0;
            tx_byte   <= '0;
            tx_req    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            boot_req  <= 1'b0;
            tx_req    <= 1'b0;
            frame_err <= abort;

            if (po_flag) begin
                case (state_q)
                    S_CMD: begin
                        cmd_q <= po_data;
                        xor_q <= po_data;
                    end
                    S_ADR2: begin
                        a2_q  <= po_data;
                        xor_q <= xor_q ^ po_data;
                    end
                    S_ADR1: begin
                        a1_q  <= po_data;
                        xor_q <= xor_q ^ po_data;
                    end
                    S_ADR0: begin
                        a0_q  <= po_data;
                        xor_q <= xor_q ^ po_data;
                    end
                    default: ;
                endcase
            end

            if (eval) begin
                tx_req <= 1'b1;
                if (frame_ok) begin
                    tx_byte <= RSP_ACK;
                    if (is_reboot) begin
                        boot_addr <= {a2_q, a1_q, a0_q};
                        boot_req  <= 1'b1;
                    end
                end else begin
                    tx_byte <= RSP_NAK;
                end
            end

            if (abort) begin
                cmd_q <= '0;
                a2_q  <= '0;
                a1_q  <= '0;
                a0_q  <= '0;
                xor_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_cmd_parser.sv
// tb/tb_uart_boot_cmd_parser.sv - self-checking bench for uart_boot_cmd_parser

module tb_uart_boot_cmd_parser;

    localparam int TMO = 1000;
    localparam int GAP = 100;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic [7:0]  po_data;
    logic        po_flag;
    logic        icap_busy;
    logic [23:0] boot_addr;
    logic        boot_req;
    logic [7:0]  tx_byte;
    logic        tx_req;
    logic        frame_err;

    uart_boot_cmd_parser #(
        .TIMEOUT_CYC (TMO),
        .CNT_W       (10)
    ) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .icap_busy (icap_busy),
        .boot_addr (boot_addr),
        .boot_req  (boot_req),
        .tx_byte   (tx_byte),
        .tx_req    (tx_req),
        .frame_err (frame_err)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        string       name;
        logic        pre55;
        logic [55:0] frame;
        logic        busy;
        logic [7:0]  exp_tx;
        logic        exp_boot;
        logic [23:0] exp_addr;
    } vec_t;

    vec_t vecs[6];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   tx_cnt = 0;
    int   ferr_cnt = 0;

    always @(negedge sclk) begin
        if (tx_req === 1'b1) tx_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        po_data = b;
        po_flag = 1'b1;
        @(posedge sclk);
        #1;
        po_flag = 1'b0;
        icap_busy = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] b;
        idle(GAP);
        if (v.pre55) begin
            send_byte(8'h55);
            idle(GAP);
        end
        for (int k = 0; k < 7; k++) begin
            b = v.frame[55 - 8*k -: 8];
            if (k == 6) icap_busy = v.busy;
            send_byte(b);
            if (k < 6) idle(GAP);
        end
        chk({v.name, "_tx_req"},    32'(tx_req),    32'd1);
        chk({v.name, "_tx_byte"},   32'(tx_byte),   32'(v.exp_tx));
        chk({v.name, "_boot_req"},  32'(boot_req),  32'(v.exp_boot));
        chk({v.name, "_boot_addr"}, 32'(boot_addr), 32'(v.exp_addr));
        idle(1);
        chk({v.name, "_tx_req_end"},   32'(tx_req),   32'd0);
        chk({v.name, "_boot_req_end"}, 32'(boot_req), 32'd0);
    endtask

    initial begin
        int   first;
        int   tx0;
        int   f0;
        vec_t hv;

        vecs[0] = '{"reboot_ok", 1'b0, 56'h55AA0112345671, 1'b0, 8'h06, 1'b1, 24'h123456};
        vecs[1] = '{"bad_chk",   1'b0, 56'h55AA0112345670, 1'b0, 8'h15, 1'b0, 24'h123456};
        vecs[2] = '{"bad_cmd",   1'b0, 56'h55AA0712345677, 1'b0, 8'h15, 1'b0, 24'h123456};
        vecs[3] = '{"ping",      1'b0, 56'h55AA0200000002, 1'b0, 8'h06, 1'b0, 24'h123456};
        vecs[4] = '{"resync",    1'b1, 56'h55AA0100100011, 1'b0, 8'h06, 1'b1, 24'h001000};
        vecs[5] = '{"busy",      1'b1, 56'h55AA0100100011, 1'b1, 8'h15, 1'b0, 24'h001000};

        rst_n = 1'b0;
        po_data = 8'h00;
        po_flag = 1'b0;
        icap_busy = 1'b0;
        idle(3);
        chk("rst_boot_addr", 32'(boot_addr), 32'h0);
        chk("rst_tx_byte",   32'(tx_byte),   32'h0);
        chk("rst_tx_req",    32'(tx_req),    32'h0);
        chk("rst_boot_req",  32'(boot_req),  32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) send_frame(vecs[i]);

        // Timeout after a partial frame, then a clean frame must be accepted.
        idle(GAP);
        f0 = ferr_cnt;
        send_byte(8'h55);
        idle(10);
        send_byte(8'hAA);
        idle(10);
        send_byte(8'h01);
        tx0 = tx_cnt;
        first = -1;
        for (int i = 1; i <= TMO + 5; i++) begin
            idle(1);
            if (frame_err === 1'b1 && first < 0) first = i;
        end
        chk("tmo_cycle", 32'(first), 32'(TMO));
        chk("tmo_pulses", 32'(ferr_cnt - f0), 32'd1);
        chk("tmo_no_tx", 32'(tx_cnt - tx0), 32'd0);
        hv = '{"after_tmo", 1'b0, 56'h55AA01ABCDEF88, 1'b0, 8'h06, 1'b1, 24'hABCDEF};
        send_frame(hv);

        // Byte lands on the terminal-count cycle: the frame continues.
        idle(GAP);
        f0 = ferr_cnt;
        send_byte(8'h55);
        idle(10);
        send_byte(8'hAA);
        idle(10);
        send_byte(8'h01);
        idle(TMO - 1);
        send_byte(8'h22);
        idle(10);
        send_byte(8'h33);
        idle(10);
        send_byte(8'h44);
        idle(10);
        send_byte(8'h54);
        chk("tc_tx_req",    32'(tx_req),    32'd1);
        chk("tc_tx_byte",   32'(tx_byte),   32'h06);
        chk("tc_boot_req",  32'(boot_req),  32'd1);
        chk("tc_boot_addr", 32'(boot_addr), 32'h223344);
        chk("tc_no_ferr",   32'(ferr_cnt - f0), 32'd0);

        // Reset in the middle of a frame.
        idle(GAP);
        send_byte(8'h55);
        idle(10);
        send_byte(8'hAA);
        idle(10);
        send_byte(8'h01);
        idle(10);
        send_byte(8'h77);
        idle(10);
        send_byte(8'h66);
        idle(3);
        rst_n = 1'b0;
        idle(1);
        chk("mrst_boot_addr", 32'(boot_addr), 32'h0);
        chk("mrst_tx_byte",   32'(tx_byte),   32'h0);
        chk("mrst_tx_req",    32'(tx_req),    32'h0);
        chk("mrst_boot_req",  32'(boot_req),  32'h0);
        chk("mrst_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        tx0 = tx_cnt;
        idle(10);
        send_byte(8'h11);
        idle(10);
        send_byte(8'h01);
        idle(5);
        chk("mrst_no_tx",     32'(tx_cnt - tx0), 32'd0);
        chk("mrst_addr_hold", 32'(boot_addr),    32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
